// File: rtl/arb_client_sequencer.sv
// Synchronous 4-phase client front-end for the async round-robin arbiter.
// Optional grant mutual-exclusion checker: define ARB_CLIENT_MUTEX_CHECK_EN.
module arb_client_sequencer #(
    parameter int REQUESTORS = 4,
    parameter int HOLD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQUESTORS-1:0] start,
    input  logic [HOLD_WIDTH-1:0] hold_cycles,
    output logic [REQUESTORS-1:0] request,
    input  logic [REQUESTORS-1:0] grant,
    output logic [REQUESTORS-1:0] done,
    output logic [7:0]            grant_count,
    output logic                  mutex_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_REL
    } state_e;

    state_e                state_q [REQUESTORS];
    state_e                state_d [REQUESTORS];
    logic [HOLD_WIDTH-1:0] cnt_q   [REQUESTORS];
    logic [HOLD_WIDTH-1:0] cnt_d   [REQUESTORS];

    logic [REQUESTORS-1:0] ff1_q;
    logic [REQUESTORS-1:0] gsync_q;
    logic [REQUESTORS-1:0] done_q;
    logic [REQUESTORS-1:0] done_d;
    logic [7:0]            gc_q;
    logic [7:0]            gc_d;

    always_comb begin
        done_d = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (start[i]) state_d[i] = S_REQ;
                end
                S_REQ: begin
                    if (gsync_q[i]) begin
                        state_d[i] = S_HOLD;
                        cnt_d[i]   = hold_cycles;
                    end
                end
                S_HOLD: begin
                    if (cnt_q[i] == '0) state_d[i] = S_REL;
                    else cnt_d[i] = cnt_q[i] - HOLD_WIDTH'(1);
                end
                S_REL: begin
                    if (!gsync_q[i]) begin
                        state_d[i] = S_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Each completion this edge counts on its own, stopping at 255.
    always_comb begin
        gc_d = gc_q;
        for (int i = 0; i < REQUESTORS; i++) begin
            if (done_d[i] && gc_d != 8'hFF) gc_d = gc_d + 8'd1;
        end
    end

    always_comb begin
        request = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            request[i] = (state_q[i] == S_REQ) || (state_q[i] == S_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q   <= '0;
            gsync_q <= '0;
            done_q  <= '0;
            gc_q    <= '0;
            for (int i = 0; i < REQUESTORS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            ff1_q   <= grant;
            gsync_q <= ff1_q;
            done_q  <= done_d;
            gc_q    <= gc_d;
            for (int i = 0; i < REQUESTORS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign done        = done_q;
    assign grant_count = gc_q;

`ifdef ARB_CLIENT_MUTEX_CHECK_EN
    logic                  mutex_q;
    logic                  mutex_d;
    logic [REQUESTORS-1:0] gsync_m1;

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign gsync_m1 = gsync_q - REQUESTORS'(1);
    assign mutex_d  = mutex_q | ((gsync_q & gsync_m1) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mutex_q <= 1'b0;
        else        mutex_q <= mutex_d;
    end

    assign mutex_err = mutex_q;
`else
    assign mutex_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_client_sequencer.sv
// Bench for arb_client_sequencer with a behavioural round-robin arbiter.
module tb_arb_client_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start = 4'b0;
    logic [3:0] hold_cycles = 4'd0;
    logic [3:0] request;
    logic [3:0] grant;
    logic [3:0] done;
    logic [7:0] grant_count;
    logic       mutex_err;

    logic [3:0] arb_g = 4'b0;
    int         ptr = 3;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0;

    int checks = 0;
    int errors = 0;
    int sb[$];
    bit free_mode = 1'b0;
    int done_cnt[4] = '{0, 0, 0, 0};
    logic [3:0] done_prev = 4'b0;

`ifdef ARB_CLIENT_MUTEX_CHECK_EN
    localparam logic MUTEX_EXP = 1'b1;
`else
    localparam logic MUTEX_EXP = 1'b0;
`endif

    arb_client_sequencer #(.REQUESTORS(4), .HOLD_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold_cycles (hold_cycles),
        .request     (request),
        .grant       (grant),
        .done        (done),
        .grant_count (grant_count),
        .mutex_err   (mutex_err)
    );

    always #5 clk = ~clk;

    assign grant = force_en ? force_val : arb_g;

    // Arbiter: grant changes mid-cycle, one owner at a time, rotating.
    always @(negedge clk) begin : arb_blk
        bit got;
        int idx;
        got = 1'b0;
        if (arb_g != 4'b0) begin
            if ((arb_g & request) == 4'b0) arb_g = 4'b0;
        end else begin
            for (int j = 1; j <= 4; j++) begin
                idx = (ptr + j) % 4;
                if (!got && request[idx]) begin
                    arb_g = 4'b0;
                    arb_g[idx] = 1'b1;
                    ptr = idx;
                    got = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must consume one queued expectation.
    always @(negedge clk) begin : mon_blk
        int pos;
        for (int i = 0; i < 4; i++) begin
            if (done[i]) begin
                chk("done_one_cycle", {31'b0, done_prev[i]}, 32'd0);
                if (free_mode) begin
                    done_cnt[i]++;
                end else begin
                    pos = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (pos < 0 && sb[j] == i) pos = j;
                    chk("sb_done_expected", {31'b0, pos >= 0}, 32'd1);
                    if (pos >= 0) sb.delete(pos);
                end
            end
        end
        done_prev = done;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        int len;
        int t;

        // Reset state
        step(2);
        chk("rst_request", {28'b0, request}, 32'h0);
        chk("rst_done", {28'b0, done}, 32'h0);
        chk("rst_count", {24'b0, grant_count}, 32'h0);
        chk("rst_mutex", {31'b0, mutex_err}, 32'h0);
        rst_n = 1'b1;
        step(5);
        chk("idle_request", {28'b0, request}, 32'h0);

        // Single channel, H=3: request high 4+H cycles with this arbiter
        hold_cycles = 4'd3;
        start = 4'b0001;
        sb.push_back(0);
        step(1);
        start = 4'b0000;
        chk("single_req_rise", {28'b0, request}, 32'h1);
        len = 1;
        t = 0;
        step(1);
        while (request[0] && t < 50) begin
            len++;
            t++;
            step(1);
        end
        chk("single_req_len", len, 32'd7);
        t = 0;
        while (grant_count != 8'd1 && t < 30) begin
            t++;
            step(1);
        end
        step(2);
        chk("single_count", {24'b0, grant_count}, 32'd1);
        chk("single_sb_empty", sb.size(), 32'd0);

        // Contention, H=2
        hold_cycles = 4'd2;
        start = 4'b0011;
        sb.push_back(0);
        sb.push_back(1);
        step(1);
        start = 4'b0000;
        chk("cont_req_both", {28'b0, request}, 32'h3);
        t = 0;
        while ((sb.size() != 0 || request != 4'b0) && t < 80) begin
            t++;
            step(1);
        end
        step(3);
        chk("cont_sb_empty", sb.size(), 32'd0);
        chk("cont_count", {24'b0, grant_count}, 32'd3);
        chk("cont_mutex", {31'b0, mutex_err}, 32'd0);

        // start[2] pulsed again while in HOLD is ignored
        hold_cycles = 4'd5;
        start = 4'b0100;
        sb.push_back(2);
        step(1);
        start = 4'b0000;
        t = 0;
        while (!grant[2] && t < 20) begin
            t++;
            step(1);
        end
        chk("ign_grant_seen", {31'b0, grant[2]}, 32'd1);
        step(3);
        chk("ign_in_hold_req", {31'b0, request[2]}, 32'd1);
        start = 4'b0100;
        step(1);
        start = 4'b0000;
        step(30);
        chk("ign_count", {24'b0, grant_count}, 32'd4);
        chk("ign_sb_empty", sb.size(), 32'd0);
        chk("ign_req_idle", {28'b0, request}, 32'h0);

        // Asynchronous reset mid-HOLD on channel 0
        hold_cycles = 4'd10;
        start = 4'b0001;
        step(1);
        start = 4'b0000;
        t = 0;
        while (!grant[0] && t < 20) begin
            t++;
            step(1);
        end
        step(4);
        chk("rst_mid_req_before", {28'b0, request}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_now", {28'b0, request}, 32'h0);
        step(1);
        chk("rst_mid_done", {28'b0, done}, 32'h0);
        chk("rst_mid_count", {24'b0, grant_count}, 32'h0);
        chk("rst_mid_mutex", {31'b0, mutex_err}, 32'h0);
        rst_n = 1'b1;
        step(12);
        chk("rst_mid_quiet_req", {28'b0, request}, 32'h0);
        chk("rst_mid_quiet_count", {24'b0, grant_count}, 32'h0);

        // Continuous start on all channels: count saturates
        free_mode = 1'b1;
        hold_cycles = 4'd0;
        start = 4'b1111;
        step(2400);
        chk("cont_all_sat", {24'b0, grant_count}, 32'd255);
        start = 4'b0000;
        t = 0;
        while (request != 4'b0 && t < 100) begin
            t++;
            step(1);
        end
        step(10);
        chk("cont_all_drained", {28'b0, request}, 32'h0);
        chk("cont_all_sat_hold", {24'b0, grant_count}, 32'd255);
        for (int i = 0; i < 4; i++)
            chk("cont_all_rotate", {31'b0, done_cnt[i] >= 20}, 32'd1);
        chk("cont_all_mutex", {31'b0, mutex_err}, 32'd0);
        free_mode = 1'b0;

        // Mutex checker with forced overlapping grants
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);
        force_val = 4'b0101;
        force_en = 1'b1;
        step(3);
        chk("mutex_set", {31'b0, mutex_err}, {31'b0, MUTEX_EXP});
        force_en = 1'b0;
        step(4);
        chk("mutex_sticky", {31'b0, mutex_err}, {31'b0, MUTEX_EXP});
        chk("mutex_no_done", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
